// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (stall/flush generation)
//
// Purpose: decides per cycle which pipeline registers hold and which load a
// bubble, covering data-memory waits, multi-cycle mul/div, EX redirects and
// load-use hazards. Also counts stalled cycles and flags a mul/div timeout.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   id_rs1, id_rs2             ID-stage source registers
//   id_use_rs1, id_use_rs2     ID instruction actually reads that source
//   ex_rd, ex_mem_read         EX destination register / EX is a load
//   ex_redirect                taken branch/jump resolved in EX
//   ex_md_start, md_done       mul/div issued in EX / mul/div result valid
//   mem_req, mem_ack           MEM data access pending / access completes
//   pc_stall..exmem_stall      hold the corresponding register
//   ifid_flush..memwb_flush    load a bubble into the corresponding register
//   md_timeout                 one-cycle pulse when mul/div never completes
//   stall_cnt                  saturating count of cycles with pc_stall=1
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_md_start,
  input  logic        md_done,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        md_timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MDWAIT, MEMWAIT} state_t;

  state_t      state, state_nxt;
  logic [5:0]  md_cnt;
  logic        ifid_stall_raw;

  logic load_use;
  logic mem_wait;
  logic md_issue;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_wait = mem_req && !mem_ack;
  assign md_issue = ex_md_start && !md_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      md_cnt    <= 6'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      // Counter only runs while waiting, so it is zero on the first MDWAIT cycle.
      if (state == MDWAIT) md_cnt <= md_cnt + 6'd1;
      else                 md_cnt <= 6'd0;
      if (pc_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_stall       = 1'b0;
    ifid_stall_raw = 1'b0;
    idex_stall     = 1'b0;
    exmem_stall    = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    memwb_flush    = 1'b0;
    md_timeout     = 1'b0;

    if (reset) begin
      // Bubbles are pushed into the pipe while in reset so no stale
      // instruction is retired when reset releases.
      state_nxt   = RUN;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            pc_stall       = 1'b1;
            ifid_stall_raw = 1'b1;
            idex_stall     = 1'b1;
            exmem_stall    = 1'b1;
            memwb_flush    = 1'b1;
            state_nxt      = MEMWAIT;
          end else if (md_issue) begin
            pc_stall       = 1'b1;
            ifid_stall_raw = 1'b1;
            idex_stall     = 1'b1;
            state_nxt      = MDWAIT;
          end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall       = 1'b1;
            ifid_stall_raw = 1'b1;
            idex_flush     = 1'b1;
          end
        end
        MEMWAIT: begin
          if (!mem_ack) begin
            pc_stall       = 1'b1;
            ifid_stall_raw = 1'b1;
            idex_stall     = 1'b1;
            exmem_stall    = 1'b1;
            memwb_flush    = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        MDWAIT: begin
          if (md_done) begin
            state_nxt = RUN;
          end else if (md_cnt == 6'd63) begin
            md_timeout = 1'b1;
            state_nxt  = RUN;
          end else begin
            pc_stall       = 1'b1;
            ifid_stall_raw = 1'b1;
            idex_stall     = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end

    // A flush always overrides a hold on IF/ID.
    ifid_stall = ifid_stall_raw && !ifid_flush;
  end

endmodule
